// File: rtl/refresh_timer.sv
// ----------------------------------------------------------------------------
// refresh_timer
//   SDRAM auto-refresh scheduler. An interval counter produces one tick every
//   refresh_count cycles. Ticks accumulate in a saturating 0..7 "owed refresh"
//   counter. A three-state FSM asks the command sequencer for a refresh slot
//   (ref_req) and, once accepted, holds ref_busy for the tRFC window.
//
// Ports
//   clk0          in   single clock, all state updates on rising edge
//   reset         in   synchronous active-high reset
//   refresh_count in   [15:0] interval in clk0 cycles, 0 disables ticks
//   ref_dur       in   [3:0]  tRFC in clk0 cycles (0 treated as 1)
//   load_rfcnt    in   new refresh_count loaded, restarts the interval
//   ref_ack       in   sequencer issues AUTO REFRESH (only valid with ref_req)
//   ref_req       out  refresh request, registered
//   ref_busy      out  refresh in progress, registered
//   ref_pending   out  [2:0] owed refreshes, saturates at 7
//   ref_urgent    out  ref_pending >= URGENT_LVL
//   ref_overflow  out  sticky: a tick was dropped at saturation
// ----------------------------------------------------------------------------
module refresh_timer #(
  parameter int URGENT_LVL = 4   // legal 1..7
) (
  input  logic        clk0,
  input  logic        reset,
  input  logic [15:0] refresh_count,
  input  logic [3:0]  ref_dur,
  input  logic        load_rfcnt,
  input  logic        ref_ack,
  output logic        ref_req,
  output logic        ref_busy,
  output logic [2:0]  ref_pending,
  output logic        ref_urgent,
  output logic        ref_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] int_cnt;
  logic        tick;
  logic        ack_ok;
  logic [2:0]  pend_nxt;
  logic        ovf_set;
  logic [3:0]  busy_cnt, busy_cnt_nxt;
  logic [3:0]  dur_q, dur_q_nxt;

  // ---------------------------------------------------------------------------
  // Interval counter. The >= compare (rather than ==) fires immediately if
  // refresh_count is lowered below the current count mid-interval, so no
  // interval is ever stretched to a 16-bit wrap. A reload suppresses the tick.
  // ---------------------------------------------------------------------------
  assign tick = (refresh_count != 16'd0) && !load_rfcnt &&
                (int_cnt >= (refresh_count - 16'd1));

  always_ff @(posedge clk0) begin
    if (reset)
      int_cnt <= 16'd0;
    else if (load_rfcnt || (refresh_count == 16'd0) || tick)
      int_cnt <= 16'd0;
    else
      int_cnt <= int_cnt + 16'd1;
  end

  // Ack only counts while a request is actually outstanding.
  assign ack_ok = ref_ack && (state == ST_REQ);

  // ---------------------------------------------------------------------------
  // Owed-refresh counter. Tick and ack in the same cycle cancel.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_nxt = ref_pending;
    ovf_set  = 1'b0;
    if (tick && !ack_ok) begin
      if (ref_pending == 3'd7)
        ovf_set = 1'b1;
      else
        pend_nxt = ref_pending + 3'd1;
    end else if (!tick && ack_ok) begin
      pend_nxt = ref_pending - 3'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      ref_pending  <= 3'd0;
      ref_overflow <= 1'b0;
    end else begin
      ref_pending  <= pend_nxt;
      if (ovf_set)
        ref_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM. busy_cnt counts 1,2,.. through BUSY and exits once it reaches the
  // tRFC captured at acceptance; starting at 1 makes ref_dur of 0 and 1 both
  // give a single busy cycle. Exit looks at pend_nxt so a tick landing in the
  // last busy cycle still re-raises the request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy_cnt <= 4'd0;
      dur_q    <= 4'd0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      dur_q    <= dur_q_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    dur_q_nxt    = dur_q;
    case (state)
      ST_IDLE: begin
        if (pend_nxt != 3'd0)
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ack_ok) begin
          state_nxt    = ST_BUSY;
          busy_cnt_nxt = 4'd1;
          dur_q_nxt    = ref_dur;
        end
      end
      ST_BUSY: begin
        if (busy_cnt >= dur_q) begin
          state_nxt    = (pend_nxt != 3'd0) ? ST_REQ : ST_IDLE;
          busy_cnt_nxt = 4'd0;
        end else begin
          busy_cnt_nxt = busy_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        busy_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign ref_req    = (state == ST_REQ);
  assign ref_busy   = (state == ST_BUSY);
  assign ref_urgent = (ref_pending >= 3'(URGENT_LVL));

endmodule
